// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment display controller.
// Segment patterns are active-low bytes: bit7 = dp, bits 6..0 = g..a.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2
    } state_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [3:0]  SHIFT_LAST = 4'd15;
    localparam logic [15:0] OVF_LIMIT  = 16'd9999;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [7:0] SEG_D0 = 8'hC0;
    localparam logic [7:0] SEG_D1 = 8'hF9;
    localparam logic [7:0] SEG_D2 = 8'hA4;
    localparam logic [7:0] SEG_D3 = 8'hB0;
    localparam logic [7:0] SEG_D4 = 8'h99;
    localparam logic [7:0] SEG_D5 = 8'h92;
    localparam logic [7:0] SEG_D6 = 8'h82;
    localparam logic [7:0] SEG_D7 = 8'hD8;
    localparam logic [7:0] SEG_D8 = 8'h80;
    localparam logic [7:0] SEG_D9 = 8'h90;

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// Combinational BCD digit to active-low segment pattern, with a blank override.
// Non-decimal codes also render blank.
module seg7_digit_enc
    import seg7_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_digit)
                4'd0:    o_seg = SEG_D0;
                4'd1:    o_seg = SEG_D1;
                4'd2:    o_seg = SEG_D2;
                4'd3:    o_seg = SEG_D3;
                4'd4:    o_seg = SEG_D4;
                4'd5:    o_seg = SEG_D5;
                4'd6:    o_seg = SEG_D6;
                4'd7:    o_seg = SEG_D7;
                4'd8:    o_seg = SEG_D8;
                4'd9:    o_seg = SEG_D9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// 16-bit binary to 4-digit 7-segment controller: handshake, serial
// double-dabble conversion, then a single atomic update of the segment bus.
//
//   state  | meaning
//   IDLE   | ready for a value; SEG holds the last result
//   SHIFT  | 16 add-3/shift steps, cnt 0..15
//   DECODE | encode digits, register SEG, pulse seg_update
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b1,
    parameter bit OVF_DASH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_value,
    output logic        in_ready,
    output logic        busy,
    output logic [31:0] SEG,
    output logic        seg_update
);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_shift;
    logic [3:0]  r_cnt;
    logic        r_ovf;
    logic [31:0] r_seg;
    logic        r_seg_update;

    logic [15:0] w_bcd_adj;
    logic [3:0]  w_digit [NUM_DIGITS];
    logic [3:0]  w_blank;
    logic [31:0] w_seg_dec;
    logic [31:0] w_seg_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == SHIFT_LAST) begin
                    w_state_next = DECODE;
                end
            end
            DECODE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_bcd_adj = '0;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            w_bcd_adj[4*n +: 4] = dabble_adj(r_shift[16 + 4*n +: 4]);
        end
    end

    // Only a 4-digit BCD field exists; carries out of the thousands nibble
    // are dropped, which only matters for values that display as overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_seg        <= {NUM_DIGITS{SEG_BLANK}};
            r_seg_update <= 1'b0;
        end else begin
            r_seg_update <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift <= {16'd0, in_value};
                        r_ovf   <= (in_value > OVF_LIMIT);
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_shift <= {w_bcd_adj, r_shift[15:0]} << 1;
                    r_cnt   <= r_cnt + 4'd1;
                end
                DECODE: begin
                    r_seg        <= w_seg_next;
                    r_seg_update <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign w_digit[g] = r_shift[16 + 4*g +: 4];

        seg7_digit_enc u_enc (
            .i_digit (w_digit[g]),
            .i_blank (w_blank[g]),
            .o_seg   (w_seg_dec[8*g +: 8])
        );
    end

    // A digit is blanked only when it and every more-significant digit are zero.
    assign w_blank[3] = BLANK_LZ && (w_digit[3] == 4'd0);
    assign w_blank[2] = w_blank[3] && (w_digit[2] == 4'd0);
    assign w_blank[1] = w_blank[2] && (w_digit[1] == 4'd0);
    assign w_blank[0] = 1'b0;

    always_comb begin
        w_seg_next = w_seg_dec;
        if (r_ovf) begin
            w_seg_next = OVF_DASH ? {NUM_DIGITS{SEG_DASH}} : {NUM_DIGITS{SEG_D9}};
        end
    end

    assign SEG        = r_seg;
    assign seg_update = r_seg_update;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Scoreboard bench for seg7_display_ctrl: two instances (blank+dash and
// no-blank+saturate) share stimulus; a reference model predicts every update.
module tb_seg7_display_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_value;
    logic        in_ready_a, busy_a, upd_a;
    logic        in_ready_b, busy_b, upd_b;
    logic [31:0] seg_a, seg_b;

    seg7_display_ctrl #(.BLANK_LZ(1'b1), .OVF_DASH(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
        .in_ready(in_ready_a), .busy(busy_a), .SEG(seg_a), .seg_update(upd_a)
    );

    seg7_display_ctrl #(.BLANK_LZ(1'b0), .OVF_DASH(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
        .in_ready(in_ready_b), .busy(busy_b), .SEG(seg_b), .seg_update(upd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint      due;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    longint      cyc    = 0;
    longint      last_k = -100;
    bit          started = 1'b0;
    bit          hs_flag = 1'b0;
    logic [31:0] held_a = 32'hFFFFFFFF;
    logic [31:0] held_b = 32'hFFFFFFFF;
    logic [7:0]  pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hD8, 8'h80, 8'h90};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Decimal digits by plain arithmetic, then the display rules.
    function automatic logic [31:0] exp_seg(input int v, input bit blank, input bit dash);
        int          d [4];
        bit          lead;
        logic [31:0] r;
        if (v > 9999) return dash ? 32'hBFBFBFBF : 32'h90909090;
        d[0] = v % 10;
        d[1] = (v / 10) % 10;
        d[2] = (v / 100) % 10;
        d[3] = v / 1000;
        lead = blank;
        r    = '0;
        for (int i = 3; i >= 0; i--) begin
            if (lead && i > 0 && d[i] == 0) begin
                r[i*8 +: 8] = 8'hFF;
            end else begin
                lead        = 1'b0;
                r[i*8 +: 8] = pat[d[i]];
            end
        end
        return r;
    endfunction

    // Reference model: accepts a value when idle, result due 17 edges later.
    always @(posedge clk) begin
        cyc++;
        hs_flag = 1'b0;
        if (rst) begin
            q.delete();
            last_k  = -100;
            held_a  = 32'hFFFFFFFF;
            held_b  = 32'hFFFFFFFF;
            started = 1'b1;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                held_a = q[0].a;
                held_b = q[0].b;
            end
            if (in_valid && cyc >= last_k + 18) begin
                last_k  = cyc;
                hs_flag = 1'b1;
                q.push_back('{due: cyc + 17,
                              a: exp_seg(int'(in_value), 1'b1, 1'b1),
                              b: exp_seg(int'(in_value), 1'b0, 1'b0)});
            end
        end
    end

    // Monitor: pops on every update pulse, checks hold and handshake status otherwise.
    always @(negedge clk) begin
        exp_t e;
        bit   idle;
        if (started) begin
            idle = (cyc >= last_k + 17);
            check("in_ready_a", {31'd0, in_ready_a}, {31'd0, idle});
            check("busy_a",     {31'd0, busy_a},     {31'd0, !idle});
            check("in_ready_b", {31'd0, in_ready_b}, {31'd0, idle});
            check("busy_b",     {31'd0, busy_b},     {31'd0, !idle});
            if (upd_a || upd_b || (q.size() > 0 && q[0].due <= cyc)) begin
                if (q.size() == 0) begin
                    check("unexpected_update", {30'd0, upd_a, upd_b}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("update_a", {31'd0, upd_a}, 32'd1);
                    check("update_b", {31'd0, upd_b}, 32'd1);
                    check("latency",  cyc[31:0], e.due[31:0]);
                    check("seg_a",    seg_a, e.a);
                    check("seg_b",    seg_b, e.b);
                end
            end else begin
                check("seg_hold_a", seg_a, held_a);
                check("seg_hold_b", seg_b, held_b);
            end
        end
    end

    task automatic send(input logic [15:0] v, input bit hold_after);
        bit got;
        got      = 1'b0;
        in_value = v;
        in_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk);
            #1;
            if (hs_flag) begin
                got = 1'b1;
                break;
            end
        end
        check("handshake_timeout", {31'd0, got}, 32'd1);
        if (!hold_after) in_valid = 1'b0;
        in_value = 16'($urandom);
    endtask

    initial begin
        in_valid = 1'b0;
        in_value = 16'd0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send(16'd1234, 1'b0);
        repeat (3) @(negedge clk);
        send(16'd0, 1'b0);
        send(16'd70, 1'b0);
        send(16'd9999, 1'b0);
        send(16'd10000, 1'b0);
        send(16'd65535, 1'b0);

        // Back-to-back with in_valid held and in_value churning while busy.
        send(16'd5, 1'b1);
        repeat (8) begin
            @(negedge clk);
            in_value = 16'($urandom);
        end
        send(16'd70, 1'b0);

        // Reset while SHIFT has cnt = 8.
        send(16'd1234, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(16'd42, 1'b0);

        for (int n = 0; n < 30; n++) begin
            logic [15:0] v;
            bit          hold;
            case ($urandom_range(0, 3))
                0:       v = 16'($urandom_range(0, 99));
                1:       v = 16'($urandom_range(9990, 10010));
                2:       v = 16'($urandom);
                default: v = 16'($urandom_range(0, 9999));
            endcase
            hold = ($urandom_range(0, 1) == 1);
            send(v, hold);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_valid = 1'b0;

        repeat (25) @(negedge clk);
        check("drain", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_display_ctrl.md
# seg7_display_ctrl

Sequential display controller for the 4-digit active-low 7-segment bank. It accepts a 16-bit binary value over a valid/ready handshake and converts it to four BCD digits with an iterative shift-add-3 (double-dabble) engine, so no divide or modulo hardware is needed. It then encodes the digits to segment patterns and updates the 32-bit segment bus atomically. It sits between game logic (move counter, timer) and the board's HEX outputs.

## Interface
- BLANK_LZ, 1: 1 = blank leading zero digits; the units digit is always shown.
- OVF_DASH, 1: for values above 9999, 1 = show four dashes, 0 = saturate the display to 9999.

- clk  in  1  single system clock; all logic is on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  in_value is offered.
- in_value  in  16  unsigned binary value to display.
- in_ready  out  1  controller can accept a value; equals (state == IDLE).
- busy  out  1  conversion in progress (state != IDLE).
- SEG  out  32  segment bus; [31:24] is thousands, down to [7:0] units. Per byte, bit7 = dp and bits 6..0 = g..a, active-low.
- seg_update  out  1  one-cycle pulse in the cycle SEG first shows a new value.

## Operation
- **States:** IDLE, SHIFT, DECODE.
- **IDLE:**
  - in_ready = 1.
  - A handshake (in_valid & in_ready at a clock edge) loads the shift register {bcd[15:0] = 0, bin[15:0] = in_value}.
  - The same handshake latches ovf = (in_value > 9999), clears cnt, and moves to SHIFT.
- **SHIFT, 16 cycles (cnt 0..15):**
  - Each cycle, add 3 to every BCD nibble that is ≥ 5, then shift the whole 32-bit register left by 1.
  - On cnt = 15, go to DECODE.
  - The conversion runs with a 4-digit BCD field only. A wrong BCD result for an ovf value is ignored.
- **DECODE (1 cycle):** register SEG from the digits, assert seg_update, return to IDLE.
- **Digit encoding (hex, active-low, dp off):** 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=D8, 8=80, 9=90. Blank = FF, dash = BF.
- **Leading-zero blanking (BLANK_LZ = 1):**
  - Thousands is blanked if it is 0.
  - Hundreds is blanked if it and thousands are 0.
  - Tens is blanked if tens, hundreds and thousands are all 0.
  - Units is never blanked.
- **Overflow:**
  - ovf & OVF_DASH = 1: SEG = BFBFBFBF.
  - ovf & OVF_DASH = 0: SEG = 90909090.
- **Holding behaviour:**
  - SEG holds its value from one DECODE to the next. Intermediate BCD states never reach SEG.
  - in_value is sampled only at the handshake; later changes to it are ignored.
  - in_valid while busy is ignored. No queueing: the requester holds in_valid until in_ready.

## Timing
- **Reset values (rst = 1 at an edge):** state = IDLE, SEG = FFFFFFFF (all blank), seg_update = 0, busy = 0, cnt = 0, ovf = 0. in_ready = 1 after the reset edge.
- **Reset mid-operation:** rst during SHIFT or DECODE aborts the conversion. There is no seg_update pulse, and SEG goes to FFFFFFFF.
- **rst with in_valid:** rst takes priority; no handshake occurs.
- **Latency:**
  - Handshake at edge k; shift edges k+1..k+16; DECODE registers SEG at edge k+17.
  - seg_update is high for the cycle following edge k+17.
- **Throughput:** next handshake no earlier than edge k+18, i.e. one value per 18 cycles.
- **Outputs:** in_ready and busy are decoded from registered state. SEG and seg_update are registered.

## Structure
- **Package seg7_pkg:**
  - state enum {IDLE, SHIFT, DECODE};
  - constants SEG_BLANK = 8'hFF and SEG_DASH = 8'hBF;
  - digit pattern constants for 0..9.
- **Sub-module seg7_digit_enc:** combinational 4-bit BCD digit + blank input → 8-bit pattern. Instantiate it four times in DECODE-path logic.
- **Top module:** FSM, 32-bit shift register, 4-bit cnt, ovf flag, blanking logic.

## Test plan
- **Basic conversion:** in_value = 1234, one handshake → SEG = F9A4B099 at edge k+17; seg_update high for exactly one cycle; busy high from k+1 through k+17.
- **Zero and blanking:** in_value = 0 → SEG = FFFFFFC0 with BLANK_LZ = 1, C0C0C0C0 with BLANK_LZ = 0. in_value = 70 with BLANK_LZ = 1 → FFFFD8C0.
- **Boundary:** in_value = 9999 → 90909090. in_value = 10000 → BFBFBFBF (OVF_DASH = 1) or 90909090 (OVF_DASH = 0). in_value = 65535 behaves the same way.
- **Back-to-back:** in_valid held high, value 5 then 70. in_ready is low while busy, and in_value changes during busy are ignored. Second handshake at edge k+18; SEG = FFFFFF92 then FFFFD8C0.
- **Reset mid-operation:** rst pulsed at SHIFT cnt = 8 → SEG = FFFFFFFF, no seg_update, busy = 0. A new value of 42 after reset gives FFFF9A4... exactly FFFFFF99A4 truncated to 32 bits, i.e. SEG = FFFF99A4, 17 cycles after its handshake.
